// File: rtl/pipe_pair_drawer.sv
// Raster-scan generator for one top/bottom pipe pair with caps, streamed over valid/ready.
// Optional macro ERASE_EN adds the erase input, which forces every emitted colour to 0.
module pipe_pair_drawer #(
    parameter int unsigned X_W      = 11,
    parameter int unsigned Y_W      = 11,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned PIPE_W   = 60,
    parameter int unsigned LIP      = 10,
    parameter int unsigned GAP      = 120
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] pipe_x,
    input  logic [Y_W-1:0] gap_y,
`ifdef ERASE_EN
    input  logic           erase,
`endif
    input  logic           ready,
    output logic           valid,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     color,
    output logic           busy,
    output logic           done
);
    localparam int unsigned SW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    typedef logic signed [SW-1:0] s_t;

    localparam s_t ZERO  = s_t'(0);
    localparam s_t ONE   = s_t'(1);
    localparam s_t S_H   = s_t'(SCREEN_H);
    localparam s_t S_WM1 = s_t'(SCREEN_W - 1);
    localparam s_t P_W   = s_t'(PIPE_W);
    localparam s_t LP    = s_t'(LIP);
    localparam s_t GP    = s_t'(GAP);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_TOP, S_BOT, S_FIN} state_t;

    state_t         r_state;
    state_t         w_nstate;
    logic [X_W-1:0] r_px;
    logic [Y_W-1:0] r_gy;
    s_t             r_x, r_y, r_hi, r_ul, r_ur;
    logic           r_cap;
    logic           r_valid, r_busy, r_done;
    logic [1:0]     r_color;
    logic           w_erase;

    s_t   w_r, w_l, w_cl, w_cr, w_gy, w_gtop, w_cap_top, w_cap_bot, w_top_end;
    s_t   w_nrow, w_nul, w_nur, w_nlo, w_nhi;
    logic w_top_en, w_bot_en, w_none, w_body_empty, w_ncap;
    logic w_emit, w_adv, w_step;

`ifdef ERASE_EN
    logic r_erase;
    assign w_erase = r_erase;
`else
    assign w_erase = 1'b0;
`endif

    // Geometry from the latched request
    assign w_r          = s_t'(r_px);
    assign w_l          = w_r - P_W;
    assign w_cl         = w_l - LP;
    assign w_cr         = w_r + LP;
    assign w_gy         = s_t'(r_gy);
    assign w_gtop       = w_gy - GP;
    assign w_cap_top    = w_gtop - LP;
    assign w_cap_bot    = w_gy + LP;
    assign w_top_en     = (w_gy >= GP);
    assign w_bot_en     = (w_gy < S_H);
    assign w_top_end    = (w_gtop < S_H) ? w_gtop : S_H;
    assign w_body_empty = (w_l > S_WM1);
    assign w_none       = (w_cr < ZERO) || (w_cl > S_WM1) || (!w_top_en && !w_bot_en);

    // Next visible row; an off-screen body is jumped over so rows never stall the stream
    always_comb begin
        w_nstate = r_state;
        w_nrow   = r_y + ONE;
        if (r_state == S_SETUP) begin
            w_nrow = ZERO;
        end
        if (r_state == S_SETUP || r_state == S_TOP) begin
            if (w_body_empty && (w_nrow < w_cap_top)) begin
                w_nrow = w_cap_top;
            end
            w_nstate = S_TOP;
            if (!w_top_en || (w_nrow >= w_top_end)) begin
                w_nstate = w_bot_en ? S_BOT : S_FIN;
                w_nrow   = w_gy;
            end
        end else if (r_state == S_BOT) begin
            if ((w_nrow >= S_H) || (w_body_empty && (w_nrow >= w_cap_bot))) begin
                w_nstate = S_FIN;
            end
        end
        if (r_state == S_SETUP && w_none) begin
            w_nstate = S_FIN;
        end
    end

    assign w_ncap = (w_nstate == S_TOP) ? (w_nrow >= w_cap_top) : (w_nrow < w_cap_bot);
    assign w_nul  = w_ncap ? w_cl : w_l;
    assign w_nur  = w_ncap ? w_cr : w_r;
    assign w_nlo  = (w_nul < ZERO) ? ZERO : w_nul;
    assign w_nhi  = (w_nur > S_WM1) ? S_WM1 : w_nur;

    assign w_emit = (r_state == S_TOP || r_state == S_BOT) && r_valid && ready;
    assign w_step = w_emit && (r_x != r_hi);
    assign w_adv  = (r_state == S_SETUP) || (w_emit && (r_x == r_hi));

    // Edge colour only where x hits an unclipped end of the row span
    function automatic logic [1:0] pix_color(input s_t px, input s_t ul, input s_t ur,
                                             input logic cap, input logic er);
        logic [1:0] c;
        if (er)                        c = 2'd0;
        else if (px == ul || px == ur) c = 2'd3;
        else                           c = cap ? 2'd2 : 2'd1;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= ZERO;
            r_y     <= ZERO;
            r_color <= 2'd0;
            r_px    <= '0;
            r_gy    <= '0;
            r_hi    <= ZERO;
            r_ul    <= ZERO;
            r_ur    <= ZERO;
            r_cap   <= 1'b0;
`ifdef ERASE_EN
            r_erase <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_px    <= pipe_x;
                        r_gy    <= gap_y;
`ifdef ERASE_EN
                        r_erase <= erase;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP, S_TOP, S_BOT: begin
                    if (w_step) begin
                        r_x     <= r_x + ONE;
                        r_color <= pix_color(r_x + ONE, r_ul, r_ur, r_cap, w_erase);
                    end else if (w_adv) begin
                        r_state <= w_nstate;
                        if (w_nstate == S_FIN) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_valid <= 1'b1;
                            r_x     <= w_nlo;
                            r_y     <= w_nrow;
                            r_hi    <= w_nhi;
                            r_ul    <= w_nul;
                            r_ur    <= w_nur;
                            r_cap   <= w_ncap;
                            r_color <= pix_color(w_nlo, w_nul, w_nur, w_ncap, w_erase);
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid = r_valid;
    assign x     = r_x[X_W-1:0];
    assign y     = r_y[Y_W-1:0];
    assign color = r_color;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_pipe_pair_drawer.sv
// Bench for pipe_pair_drawer: scenario tasks checked against a row-by-row pixel list model.
module tb_pipe_pair_drawer;
    typedef logic [23:0] pix_t;

    logic        clk = 1'b0;
    logic        reset, start, ready, erase;
    logic [10:0] pipe_x, gap_y;
    logic        valid, busy, done;
    logic [10:0] x, y;
    logic [1:0]  color;

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t obs_q[$];
    pix_t exp_q[$];
    int   first_cyc, last_hs, done_cyc, unstable, busy_err, first_bad;
    bit   timed_out;

    pipe_pair_drawer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .pipe_x (pipe_x),
        .gap_y  (gap_y),
`ifdef ERASE_EN
        .erase  (erase),
`endif
        .ready  (ready),
        .valid  (valid),
        .x      (x),
        .y      (y),
        .color  (color),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Expected pixel list straight from the geometry rules, one screen row at a time
    function automatic void build_model(input int px, input int gy, input bit er);
        int l, r, cl, cr, gt, ul, ur, lo, hi;
        bit cap, in_pipe;
        logic [1:0] col;
        exp_q.delete();
        l = px - 60; r = px; cl = l - 10; cr = r + 10; gt = gy - 120;
        for (int row = 0; row < 480; row++) begin
            in_pipe = 0; cap = 0;
            if (gy >= 120 && row < gt) begin
                in_pipe = 1; cap = (row >= gt - 10);
            end else if (gy < 480 && row >= gy) begin
                in_pipe = 1; cap = (row < gy + 10);
            end
            if (in_pipe) begin
                ul = cap ? cl : l;
                ur = cap ? cr : r;
                lo = (ul < 0) ? 0 : ul;
                hi = (ur > 639) ? 639 : ur;
                for (int c = lo; c <= hi; c++) begin
                    if (er)                    col = 2'd0;
                    else if (c == ul || c == ur) col = 2'd3;
                    else                       col = cap ? 2'd2 : 2'd1;
                    exp_q.push_back({11'(c), 11'(row), col});
                end
            end
        end
    endfunction

    function automatic int stream_errs(input int n);
        int e = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                e++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return e;
    endfunction

    function automatic int color_at(input int cx, input int cy);
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i][23:13] == 11'(cx) && obs_q[i][12:2] == 11'(cy)) return int'(obs_q[i][1:0]);
        return -1;
    endfunction

    function automatic int row_count(input int cy);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][12:2] == 11'(cy)) n++;
        return n;
    endfunction

    task automatic start_draw(input int px, input int gy, input bit er);
        @(negedge clk);
        pipe_x = 11'(px); gap_y = 11'(gy); erase = er; start = 1'b1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: ready high; 1: 5-cycle stall at first pixel, 1-cycle stall at every 7th; 2: random
    task automatic capture(input int mode, input int max_pix);
        int   cyc, stall;
        bit   held;
        pix_t cur, prev;
        obs_q.delete();
        first_cyc = -1; last_hs = -1; done_cyc = -1; unstable = 0; busy_err = 0; timed_out = 0;
        cyc = 0; stall = 0; held = 0; prev = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) begin done_cyc = cyc; break; end
            if (cyc > 40000) begin timed_out = 1; break; end
            if (valid === 1'b1) begin
                cur = {x, y, color};
                if (busy !== 1'b1) busy_err++;
                if (held && cur !== prev) unstable++;
                if (first_cyc < 0) first_cyc = cyc;
                if (!held && mode == 1)
                    stall = (obs_q.size() == 0) ? 5 : ((obs_q.size() % 7 == 6) ? 1 : 0);
                if (mode == 1) begin
                    ready = (stall == 0);
                    if (stall > 0) stall--;
                end else if (mode == 2) ready = ($urandom_range(0, 3) != 0);
                else ready = 1'b1;
                if (ready) begin
                    obs_q.push_back(cur);
                    last_hs = cyc;
                    held = 0;
                    if (max_pix > 0 && obs_q.size() == max_pix) break;
                end else begin
                    held = 1;
                    prev = cur;
                end
            end else begin
                held  = 0;
                ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready = 1'b1; pipe_x = '0; gap_y = '0; erase = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (x !== 11'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", x); end
        n_cmp++; if (y !== 11'd0) begin n_bad++; $display("FAIL reset_y: got %0d expected 0", y); end
        n_cmp++; if (color !== 2'd0) begin n_bad++; $display("FAIL reset_color: got %0d expected 0", color); end
    endtask

    task automatic test_nominal();
        int e;
        start_draw(100, 300, 1'b0);
        capture(0, 0);
        build_model(100, 300, erase);
        e = stream_errs(22360);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL nominal_timeout: got timeout expected done"); end
        n_cmp++; if (obs_q.size() != 22360) begin n_bad++; $display("FAIL nominal_count: got %0d expected 22360", obs_q.size()); end
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL nominal_stream: %0d bad pixels, first at %0d got %h expected %h", e, first_bad, (first_bad < obs_q.size()) ? obs_q[first_bad] : 24'hx, exp_q[first_bad]); end
        n_cmp++; if (obs_q.size() == 0 || obs_q[0] !== {11'd40, 11'd0, 2'd3}) begin n_bad++; $display("FAIL nominal_first: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 24'hx, {11'd40, 11'd0, 2'd3}); end
        n_cmp++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {11'd100, 11'd479, 2'd3}) begin n_bad++; $display("FAIL nominal_last: got %h expected %h", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 24'hx, {11'd100, 11'd479, 2'd3}); end
        n_cmp++; if (row_count(170) != 81) begin n_bad++; $display("FAIL nominal_cap_row: got %0d expected 81", row_count(170)); end
        n_cmp++; if (row_count(310) != 61) begin n_bad++; $display("FAIL nominal_body_row: got %0d expected 61", row_count(310)); end
        n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL nominal_latency: got %0d expected 2", first_cyc); end
        n_cmp++; if (done_cyc - last_hs != 1) begin n_bad++; $display("FAIL nominal_done_gap: got %0d expected 1", done_cyc - last_hs); end
        n_cmp++; if (busy_err != 0) begin n_bad++; $display("FAIL nominal_busy: got %0d expected 0", busy_err); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL nominal_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_backpressure();
        int e, exp_done;
        start_draw(100, 300, 1'b0);
        capture(1, 0);
        build_model(100, 300, 1'b0);
        e = stream_errs(22360);
        exp_done = 2 + 22360 + 5 + ((22360 - 7) / 7 + 1);
        n_cmp++; if (obs_q.size() != 22360) begin n_bad++; $display("FAIL bp_count: got %0d expected 22360", obs_q.size()); end
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL bp_stream: %0d bad pixels, first at %0d", e, first_bad); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
        n_cmp++; if (done_cyc != exp_done) begin n_bad++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cyc, exp_done); end
    endtask

    task automatic test_left_clip();
        int e;
        start_draw(20, 300, 1'b0);
        capture(0, 0);
        build_model(20, 300, 1'b0);
        e = stream_errs(exp_q.size());
        n_cmp++; if (obs_q.size() != 7760) begin n_bad++; $display("FAIL clip_count: got %0d expected 7760", obs_q.size()); end
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL clip_stream: %0d bad pixels, first at %0d", e, first_bad); end
        n_cmp++; if (color_at(0, 0) != 1) begin n_bad++; $display("FAIL clip_0_0: got %0d expected 1", color_at(0, 0)); end
        n_cmp++; if (color_at(20, 0) != 3) begin n_bad++; $display("FAIL clip_20_0: got %0d expected 3", color_at(20, 0)); end
        n_cmp++; if (color_at(30, 170) != 3) begin n_bad++; $display("FAIL clip_30_170: got %0d expected 3", color_at(30, 170)); end
        n_cmp++; if (color_at(0, 170) != 2) begin n_bad++; $display("FAIL clip_0_170: got %0d expected 2", color_at(0, 170)); end
    endtask

    task automatic test_absent();
        start_draw(100, 100, 1'b0);
        capture(0, 1);
        reset_pulse();
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== {11'd30, 11'd100, 2'd3}) begin n_bad++; $display("FAIL absent_top_first: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 24'hx, {11'd30, 11'd100, 2'd3}); end
        n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL absent_top_latency: got %0d expected 2", first_cyc); end
        start_draw(720, 300, 1'b0);
        capture(0, 0);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL absent_all_count: got %0d expected 0", obs_q.size()); end
        n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL absent_all_done: got %0d expected 2", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        start_draw(100, 300, 1'b0);
        capture(0, 500);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (obs_q.size() != 500) begin n_bad++; $display("FAIL mid_count: got %0d expected 500", obs_q.size()); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", valid); end
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL mid_no_done: got %0d pulses expected 0", dn); end
        start_draw(100, 300, 1'b0);
        capture(0, 1);
        reset_pulse();
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== {11'd40, 11'd0, 2'd3}) begin n_bad++; $display("FAIL mid_restart: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 24'hx, {11'd40, 11'd0, 2'd3}); end
        n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL mid_restart_latency: got %0d expected 2", first_cyc); end
    endtask

    task automatic test_random();
        int px, gy, n, e;
        for (int i = 0; i < 6; i++) begin
            px = $urandom_range(0, 760);
            gy = $urandom_range(0, 700);
            start_draw(px, gy, 1'b0);
            capture(2, 300);
            reset_pulse();
            build_model(px, gy, 1'b0);
            n = (done_cyc >= 0) ? exp_q.size() : 300;
            e = stream_errs(n);
            n_cmp++; if (e != 0 || (done_cyc >= 0 && obs_q.size() != exp_q.size())) begin n_bad++; $display("FAIL rand_prefix px=%0d gy=%0d: %0d bad, got %0d pixels expected %0d", px, gy, e, obs_q.size(), n); end
            n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL rand_hold px=%0d gy=%0d: got %0d expected 0", px, gy, unstable); end
        end
        for (int i = 0; i < 4; i++) begin
            px = $urandom_range(700, 712);
            gy = $urandom_range(0, 700);
            start_draw(px, gy, 1'b0);
            capture(2, 0);
            build_model(px, gy, 1'b0);
            e = stream_errs(exp_q.size());
            n_cmp++; if (timed_out || obs_q.size() != exp_q.size() || e != 0) begin n_bad++; $display("FAIL edge_stream px=%0d gy=%0d: got %0d pixels expected %0d, %0d bad", px, gy, obs_q.size(), exp_q.size(), e); end
            if (exp_q.size() > 0) begin
                n_cmp++; if (done_cyc - last_hs != 1) begin n_bad++; $display("FAIL edge_done_gap px=%0d gy=%0d: got %0d expected 1", px, gy, done_cyc - last_hs); end
            end
        end
    endtask

`ifdef ERASE_EN
    task automatic test_erase();
        int e;
        start_draw(100, 300, 1'b1);
        capture(0, 0);
        build_model(100, 300, 1'b1);
        e = stream_errs(22360);
        n_cmp++; if (obs_q.size() != 22360) begin n_bad++; $display("FAIL erase_count: got %0d expected 22360", obs_q.size()); end
        n_cmp++; if (e != 0) begin n_bad++; $display("FAIL erase_stream: %0d bad pixels, first at %0d", e, first_bad); end
        erase = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_left_clip();
        test_absent();
        test_reset_mid();
        test_random();
`ifdef ERASE_EN
        test_erase();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
